// File: rtl/pic_int_cond_if.sv
// ---------------------------------------------------------------------------
// wb_if : 32-bit Wishbone classic bus bundle.
//
// Signals:
//   adr   - byte address            (master -> slave)
//   dat_w - write data              (master -> slave)
//   dat_r - read data               (slave  -> master)
//   we    - write enable            (master -> slave)
//   stb   - strobe                  (master -> slave)
//   cyc   - bus cycle valid         (master -> slave)
//   ack   - transfer acknowledge    (slave  -> master)
//   err   - transfer error          (slave  -> master)
// ---------------------------------------------------------------------------
interface wb_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        we;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        err;

    modport slave  (input  adr, dat_w, we, stb, cyc,
                    output dat_r, ack, err);
    modport master (output adr, dat_w, we, stb, cyc,
                    input  dat_r, ack, err);
endinterface

// File: rtl/pic_int_cond.sv
// ---------------------------------------------------------------------------
// pic_int_cond : interrupt conditioning stage feeding or1200_pic.pic_int.
//
// Each raw line is synchronized (2 flops), optionally glitch-filtered,
// polarity-adjusted, and then either passed as a level or captured as a
// rising edge of the conditioned signal into a sticky PEND bit.
//
// Ports:
//   clk        - clock
//   rstn       - synchronous, active-low reset
//   irq_raw_i  - asynchronous raw interrupt lines [NUM_INTS]
//   int_o      - registered conditioned interrupts [NUM_INTS]
//   s          - Wishbone slave register port
//
// Register map (ADR[3:2]; other address bits ignored):
//   0x0 RAW  (RO) synchronized/filtered lines before polarity
//   0x4 MODE (RW) 1 = edge, 0 = level
//   0x8 POL  (RW) 1 = active-low / falling edge
//   0xC PEND      read: edge lines -> pending, level lines -> cond
//                 write: 1 clears pending on edge lines
//
// Build option: define PIC_INT_COND_FILTER_EN to insert a per-line
// FILTER_CYCLES glitch filter between the synchronizer and cond.
// ---------------------------------------------------------------------------
module pic_int_cond #(
    parameter int NUM_INTS      = 20,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_INTS-1:0] irq_raw_i,
    output logic [NUM_INTS-1:0] int_o,
    wb_if.slave                 s
);

    typedef enum logic [1:0] {
        REG_RAW  = 2'd0,
        REG_MODE = 2'd1,
        REG_POL  = 2'd2,
        REG_PEND = 2'd3
    } reg_sel_e;

    logic [NUM_INTS-1:0] sync1;
    logic [NUM_INTS-1:0] raw_s;
    logic [NUM_INTS-1:0] raw_f;
    logic [NUM_INTS-1:0] cond;
    logic [NUM_INTS-1:0] prev;
    logic [NUM_INTS-1:0] mode;
    logic [NUM_INTS-1:0] pol;
    logic [NUM_INTS-1:0] pend;

    logic [NUM_INTS-1:0] mode_nxt;
    logic [NUM_INTS-1:0] pol_nxt;
    logic [NUM_INTS-1:0] pend_nxt;
    logic [NUM_INTS-1:0] prev_nxt;
    logic [NUM_INTS-1:0] changed;
    logic [NUM_INTS-1:0] w1c;
    logic [NUM_INTS-1:0] rise;

    logic        cs;
    logic        wr;
    logic        ack;
    logic [31:0] dat_r;
    logic [31:0] rd_data;
    reg_sel_e    sel;
    logic        unused_bus_bits;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, regardless of block order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1 <= '0;
            raw_s <= '0;
        end else begin
            sync1 <= irq_raw_i;
            raw_s <= sync1;
        end
    end

`ifdef PIC_INT_COND_FILTER_EN
    // Filtered value follows raw_s only after FILTER_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    logic [3:0] flt_cnt [NUM_INTS];

    // NOTE: the counter array is small control state, not a RAM, so it is
    // reset like any other flop; a true memory would be left unreset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            raw_f <= '0;
            for (int i = 0; i < NUM_INTS; i++) flt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_INTS; i++) begin
                if (raw_s[i] != raw_f[i]) begin
                    if (flt_cnt[i] == 4'(FILTER_CYCLES - 1)) begin
                        raw_f[i]   <= raw_s[i];
                        flt_cnt[i] <= '0;
                    end else begin
                        flt_cnt[i] <= flt_cnt[i] + 4'd1;
                    end
                end else begin
                    flt_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign raw_f = raw_s;
`endif

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    assign cs  = s.stb & s.cyc & ~ack;
    assign wr  = cs & s.we;
    assign sel = reg_sel_e'(s.adr[3:2]);

    // Only ADR[3:2] and the low NUM_INTS data bits carry meaning.
    assign unused_bus_bits = ^{s.adr, s.dat_w};

    assign cond = raw_f ^ pol;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mode_nxt = mode;
        pol_nxt  = pol;
        w1c      = '0;
        rd_data  = '0;

        if (wr) begin
            case (sel)
                REG_MODE: mode_nxt = s.dat_w[NUM_INTS-1:0];
                REG_POL:  pol_nxt  = s.dat_w[NUM_INTS-1:0];
                REG_PEND: w1c      = s.dat_w[NUM_INTS-1:0];
                default:  ;
            endcase
        end

        // Reconfigured lines drop any pending state and must not see the
        // polarity flip itself as an edge.
        changed  = (mode_nxt ^ mode) | (pol_nxt ^ pol);
        rise     = cond & ~prev & mode & ~changed;
        // Set is OR-ed in after the clear so a coincident edge wins.
        pend_nxt = (pend & ~w1c & ~changed) | rise;
        // For unchanged bits this equals cond; for changed bits it is the
        // cond under the new polarity, so the next cycle sees no edge.
        prev_nxt = raw_f ^ pol_nxt;

        case (sel)
            REG_RAW:  rd_data[NUM_INTS-1:0] = raw_f;
            REG_MODE: rd_data[NUM_INTS-1:0] = mode;
            REG_POL:  rd_data[NUM_INTS-1:0] = pol;
            REG_PEND: rd_data[NUM_INTS-1:0] = (mode & pend) | (~mode & cond);
            default:  ;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers and bus response
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode  <= '0;
            pol   <= '0;
            pend  <= '0;
            prev  <= '0;
            int_o <= '0;
            ack   <= 1'b0;
            dat_r <= '0;
        end else begin
            mode  <= mode_nxt;
            pol   <= pol_nxt;
            pend  <= pend_nxt;
            prev  <= prev_nxt;
            int_o <= (mode & pend_nxt) | (~mode & cond);
            ack   <= cs;
            if (cs) dat_r <= rd_data;
        end
    end

    assign s.ack   = ack;
    assign s.dat_r = dat_r;
    assign s.err   = 1'b0;

endmodule

// File: tb/tb_pic_int_cond.sv
// ---------------------------------------------------------------------------
// tb_pic_int_cond : self-checking bench for pic_int_cond (NUM_INTS = 20).
// Register reads push their expected value onto a scoreboard queue when the
// access is issued and are popped and compared when ACK returns.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pic_int_cond;

    localparam int N  = 20;
    localparam int FC = 4;
`ifdef PIC_INT_COND_FILTER_EN
    localparam int LAT = 3 + FC;
`else
    localparam int LAT = 3;
`endif
    // Edge pulse long enough to survive the filter when it is present.
    localparam int PULSE = LAT - 1;

    localparam logic [31:0] A_RAW  = 32'h0;
    localparam logic [31:0] A_MODE = 32'h4;
    localparam logic [31:0] A_POL  = 32'h8;
    localparam logic [31:0] A_PEND = 32'hC;
    localparam logic [31:0] MASK   = 32'h000F_FFFF;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] irq_raw_i;
    logic [N-1:0] int_o;

    wb_if bus ();

    pic_int_cond #(.NUM_INTS(N), .FILTER_CYCLES(FC)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .irq_raw_i (irq_raw_i),
        .int_o     (int_o),
        .s         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_item_t;
    sb_item_t sb_q[$];

    typedef struct {
        logic [31:0] irq;
        logic [31:0] pol_wr;
        logic [31:0] pol_rd;
        logic [31:0] exp_int;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One Wishbone access, issued at the current time; returns 1 ns after
    // the ACK edge with STB/CYC already dropped.
    task automatic wb_access(input logic [31:0] adr, input logic we,
                             input logic [31:0] dat, input logic [31:0] exp,
                             input string name);
        int waited;
        waited    = 0;
        bus.adr   = adr;
        bus.we    = we;
        bus.dat_w = dat;
        bus.stb   = 1'b1;
        bus.cyc   = 1'b1;
        if (!we) sb_q.push_back('{name, exp});
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!bus.ack && waited < 8);
        bus.stb = 1'b0;
        bus.cyc = 1'b0;
        bus.we  = 1'b0;
        if (!bus.ack) begin
            check({name, "_ack_timeout"}, 32'd0, 32'd1);
            if (!we) void'(sb_q.pop_front());
        end else if (!we) begin
            sb_item_t it;
            it = sb_q.pop_front();
            check(it.name, bus.dat_r, it.exp);
        end
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        wb_access(adr, 1'b1, dat, 32'd0, "wr");
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        wb_access(adr, 1'b0, 32'd0, exp, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        //              irq         pol_wr        pol_rd        exp_int
        vecs[0] = '{32'h00000, 32'h00000,    32'h00000, 32'h00000};
        vecs[1] = '{32'hFFFFF, 32'h00000,    32'h00000, 32'hFFFFF};
        vecs[2] = '{32'h00000, 32'h00001,    32'h00001, 32'h00001};
        vecs[3] = '{32'h00001, 32'h00001,    32'h00001, 32'h00000};
        vecs[4] = '{32'hA5A5A, 32'h0F0F0,    32'h0F0F0, 32'hAAAAA};
        vecs[5] = '{32'h12345, 32'hFFFFFFFF, 32'h000FFFFF, 32'hEDCBA};

        bus.adr = '0; bus.dat_w = '0; bus.we = 1'b0; bus.stb = 1'b0; bus.cyc = 1'b0;
        rstn      = 1'b0;
        irq_raw_i = '1;

        // ---------------- reset ----------------
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_int_o", 32'(int_o), 32'd0);
        check("rst_ack",   32'(bus.ack), 32'd0);
        check("rst_dat_r", bus.dat_r, 32'd0);
        check("err_tied",  32'(bus.err), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick(LAT - 1);
        check("rst_release_early", 32'(int_o), 32'd0);
        tick(1);
        check("rst_release_lat", 32'(int_o), MASK);
        rd(A_MODE, 32'd0, "rst_mode");
        rd(A_POL,  32'd0, "rst_pol");
        rd(A_PEND, MASK,  "rst_pend_level_cond");
        tick(1);
        check("ack_single_pulse", 32'(bus.ack), 32'd0);

        // ---------------- level mode table ----------------
        for (int i = 0; i < 6; i++) begin
            wr(A_POL, vecs[i].pol_wr);
            irq_raw_i = vecs[i].irq[N-1:0];
            tick(LAT + 1);
            check($sformatf("vec%0d_int_o", i), 32'(int_o), vecs[i].exp_int);
            rd(A_RAW, vecs[i].irq, $sformatf("vec%0d_raw", i));
            rd(32'hABCD_0008, vecs[i].pol_rd, $sformatf("vec%0d_pol_rd", i));
        end

        // ---------------- level active-low latency ----------------
        wr(A_POL, 32'h1);
        irq_raw_i = 20'h00001;
        tick(LAT + 1);
        check("lvl_low_idle", 32'(int_o), 32'd0);
        irq_raw_i = 20'h00000;
        tick(LAT - 1);
        check("lvl_low_assert_early", 32'(int_o), 32'd0);
        tick(1);
        check("lvl_low_assert_lat", 32'(int_o), 32'h1);
        rd(A_RAW, 32'h0, "lvl_low_raw");
        irq_raw_i = 20'h00001;
        tick(LAT);
        check("lvl_low_deassert_lat", 32'(int_o), 32'd0);

        // ---------------- edge capture and W1C ----------------
        wr(A_POL, 32'h0);
        irq_raw_i = '0;
        tick(LAT + 1);
        wr(A_MODE, 32'h4);
        tick(1);
        irq_raw_i = 20'h00004;
        tick(LAT - 1);
        check("edge_rise_early", 32'(int_o), 32'd0);
        tick(1);
        check("edge_rise_lat", 32'(int_o), 32'h4);
        tick(PULSE - LAT > 0 ? PULSE - LAT : 0);
        irq_raw_i = '0;
        tick(LAT + 3);
        check("edge_held", 32'(int_o), 32'h4);
        rd(A_PEND, 32'h4, "edge_pend");
        wr(A_PEND, 32'h4);
        check("w1c_int_same_edge", 32'(int_o), 32'd0);
        rd(A_PEND, 32'h0, "w1c_pend");

        // ---------------- set beats clear ----------------
        tick(1);
        irq_raw_i = 20'h00004;
        tick(LAT - 1);
        wr(A_PEND, 32'h4);      // sampled on the same edge the rise is seen
        check("set_wins_int", 32'(int_o), 32'h4);
        rd(A_PEND, 32'h4, "set_wins_pend");

        // ---------------- MODE/POL change suppression ----------------
        irq_raw_i = 20'h0000C;
        tick(LAT + 1);
        check("supp_level_line3", 32'(int_o), 32'hC);
        wr(A_MODE, 32'hC);
        tick(LAT + 1);
        rd(A_PEND, 32'h4, "supp_mode_chg");
        wr(A_POL, 32'h8);
        tick(LAT + 1);
        rd(A_PEND, 32'h4, "supp_pol_set");
        wr(A_POL, 32'h0);
        tick(LAT + 1);
        rd(A_PEND, 32'h4, "supp_pol_clr");
        check("supp_int_o", 32'(int_o), 32'h4);

        // ---------------- reset during a write ----------------
        rstn      = 1'b0;
        bus.adr   = A_MODE;
        bus.we    = 1'b1;
        bus.dat_w = 32'hFFFF_FFFF;
        bus.stb   = 1'b1;
        bus.cyc   = 1'b1;
        tick(1);
        check("rst_mid_ack", 32'(bus.ack), 32'd0);
        bus.stb = 1'b0; bus.cyc = 1'b0; bus.we = 1'b0;
        rstn = 1'b1;
        irq_raw_i = '0;
        tick(1);
        rd(A_MODE, 32'd0, "rst_mid_mode_lost");

`ifdef PIC_INT_COND_FILTER_EN
        // ---------------- glitch filter ----------------
        tick(LAT + 2);
        irq_raw_i = 20'h00002;
        tick(3);
        irq_raw_i = '0;
        seen = 1'b0;
        repeat (15) begin
            tick(1);
            seen |= int_o[1];
        end
        check("flt_short_pulse", 32'(seen), 32'd0);
        irq_raw_i = 20'h00002;
        tick(4);
        irq_raw_i = '0;
        tick(2);
        check("flt_pulse_early", 32'(int_o), 32'd0);
        tick(1);
        check("flt_pulse_lat", 32'(int_o), 32'h2);
`else
        seen = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
